// File: rtl/frame_byte_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_byte_seq_if
//  Description : Handshake/bus bundle between the send controller, the frame
//                byte sequencer and the downstream preamble/FCS stage.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    start_sending      one-cycle frame request
//    segment_num_inter  segment number for the requested frame (16)
//    txid_inter         transmission id for the requested frame (8)
//    aux                frame-set counter for the requested frame (8)
//    data_ready         downstream accepts data_out this cycle
//    busy               sequencer is working on a frame or its gap
//    data_out           frame byte (8)
//    data_valid         data_out is valid
//    data_sof           first byte of the frame
//    data_eof           last payload byte
//  Modports
//    master : controller / downstream side (drives requests and data_ready)
//    slave  : the sequencer itself
// ============================================================================
interface frame_byte_seq_if;
    logic        start_sending;
    logic [15:0] segment_num_inter;
    logic [7:0]  txid_inter;
    logic [7:0]  aux;
    logic        data_ready;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_sof;
    logic        data_eof;

    modport master (
        output start_sending, segment_num_inter, txid_inter, aux, data_ready,
        input  busy, data_out, data_valid, data_sof, data_eof
    );

    modport slave (
        input  start_sending, segment_num_inter, txid_inter, aux, data_ready,
        output busy, data_out, data_valid, data_sof, data_eof
    );
endinterface
`default_nettype wire

// File: rtl/frame_byte_seq.sv
`default_nettype none
// ============================================================================
//  Module      : frame_byte_seq
//  Description : Emits one Ethernet-style frame byte stream per accepted start:
//                18 header bytes (DST MAC, SRC MAC, EtherType, txid, aux,
//                segment number) followed by PAYLOAD_LEN incrementing payload
//                bytes, then holds busy for IFG idle cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk125MHz  in   sole clock, rising edge
//    rst        in   asynchronous active-high reset
//    bus        slave modport of frame_byte_seq_if (request, data, handshake)
// ============================================================================
module frame_byte_seq #(
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_01_02_03,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 64,
    parameter int          IFG         = 12
) (
    input  wire logic        clk125MHz,
    input  wire logic        rst,
    frame_byte_seq_if.slave  bus
);

    localparam logic [10:0] c_HDR_LAST = 11'd17;
    localparam logic [10:0] c_EOF_IDX  = 11'(17 + PAYLOAD_LEN);
    localparam logic [8:0]  c_IFG      = 9'(IFG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [10:0] r_index;
    logic [7:0]  r_gap;
    logic [15:0] r_seg;
    logic [7:0]  r_txid;
    logic [7:0]  r_aux;
    logic [7:0]  r_data;
    logic        r_sof;
    logic        r_eof;

    logic        w_xfer;
    logic        w_gap_done;
    logic [10:0] w_index_next;
    logic [7:0]  w_byte_next;

    assign w_xfer       = ((r_state == HEADER) || (r_state == PAYLOAD)) && bus.data_ready;
    assign w_index_next = r_index + 11'd1;
    // Widened compare so the last gap cycle is found without underflow.
    assign w_gap_done   = (({1'b0, r_gap} + 9'd1) == c_IFG);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_sending) w_state_next = HEADER;
            HEADER:  if (w_xfer && (r_index == c_HDR_LAST)) w_state_next = PAYLOAD;
            PAYLOAD: if (w_xfer && (r_index == c_EOF_IDX))
                         w_state_next = (c_IFG == 9'd0) ? IDLE : GAP;
            GAP:     if (w_gap_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte that follows the current one. Output bytes are registered, so
    // the mux looks one index ahead; index 0 is loaded at start.
    // Payload: (seg[7:0] + (idx - 18)) mod 256 only needs the low 8 bits.
    // ------------------------------------------------------------------
    always_comb begin
        w_byte_next = r_seg[7:0] + w_index_next[7:0] - 8'd18;
        case (w_index_next)
            11'd1:   w_byte_next = DST_MAC[39:32];
            11'd2:   w_byte_next = DST_MAC[31:24];
            11'd3:   w_byte_next = DST_MAC[23:16];
            11'd4:   w_byte_next = DST_MAC[15:8];
            11'd5:   w_byte_next = DST_MAC[7:0];
            11'd6:   w_byte_next = SRC_MAC[47:40];
            11'd7:   w_byte_next = SRC_MAC[39:32];
            11'd8:   w_byte_next = SRC_MAC[31:24];
            11'd9:   w_byte_next = SRC_MAC[23:16];
            11'd10:  w_byte_next = SRC_MAC[15:8];
            11'd11:  w_byte_next = SRC_MAC[7:0];
            11'd12:  w_byte_next = ETHERTYPE[15:8];
            11'd13:  w_byte_next = ETHERTYPE[7:0];
            11'd14:  w_byte_next = r_txid;
            11'd15:  w_byte_next = r_aux;
            11'd16:  w_byte_next = r_seg[15:8];
            11'd17:  w_byte_next = r_seg[7:0];
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched request fields, byte index, output byte and marks
    // ------------------------------------------------------------------
    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            r_index <= '0;
            r_seg   <= '0;
            r_txid  <= '0;
            r_aux   <= '0;
            r_data  <= '0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (bus.start_sending) begin
                r_seg   <= bus.segment_num_inter;
                r_txid  <= bus.txid_inter;
                r_aux   <= bus.aux;
                r_index <= '0;
                r_data  <= DST_MAC[47:40];
                r_sof   <= 1'b1;
                r_eof   <= 1'b0;
            end
        end else if (w_xfer) begin
            r_index <= w_index_next;
            // After the eof byte leaves, the outputs simply hold.
            if (r_index != c_EOF_IDX) begin
                r_data <= w_byte_next;
                r_sof  <= 1'b0;
                r_eof  <= (w_index_next == c_EOF_IDX);
            end
        end
    end

    // Gap counter runs only in GAP, so it always enters GAP at zero.
    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else if (r_state == GAP) begin
            r_gap <= r_gap + 8'd1;
        end else begin
            r_gap <= '0;
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.data_valid = (r_state == HEADER) || (r_state == PAYLOAD);
    assign bus.data_out   = r_data;
    assign bus.data_sof   = r_sof;
    assign bus.data_eof   = r_eof;

endmodule
`default_nettype wire

// File: doc/frame_byte_seq.md
FRAME_BYTE_SEQ -- requirements
Module: frame_byte_seq

Interface
REQ-001 Parameter DST_MAC, default 48'hFF_FF_FF_FF_FF_FF, destination MAC sent MSB byte first.
REQ-002 Parameter SRC_MAC, default 48'h00_0A_35_01_02_03, source MAC sent MSB byte first.
REQ-003 Parameter ETHERTYPE, default 16'h88B5, EtherType field sent MSB byte first.
REQ-004 Parameter PAYLOAD_LEN, default 64, payload bytes per frame, legal range 1..1500.
REQ-005 Parameter IFG, default 12, idle cycles after the last accepted byte, legal range 0..255.
REQ-006 clk125MHz  input  1  sole clock; all logic is on its rising edge.
REQ-007 rst  input  1  reset; asynchronous and active-high.
REQ-008 start_sending  input  1  one-cycle frame request from the send controller.
REQ-009 segment_num_inter  input  16  segment number for the requested frame.
REQ-010 txid_inter  input  8  transmission id for the requested frame.
REQ-011 aux  input  8  frame-set counter for the requested frame.
REQ-012 data_ready  input  1  downstream (preamble/FCS stage) accepts data_out this cycle.
REQ-013 busy  output  1  high from the cycle after an accepted start until the IFG expires.
REQ-014 data_out  output  8  frame byte.
REQ-015 data_valid  output  1  data_out is valid.
REQ-016 data_sof  output  1  marks the first byte of the frame (index 0).
REQ-017 data_eof  output  1  marks the last payload byte.

Function
REQ-018 The state machine SHALL have the states IDLE, HEADER, PAYLOAD and GAP.
REQ-019 In IDLE, start_sending=1 SHALL latch segment_num_inter, txid_inter and aux, clear byte index to 0, and enter HEADER next cycle.
REQ-020 start_sending SHALL be ignored in every state other than IDLE, and the latched fields SHALL not change mid-frame.
REQ-021 busy SHALL be 0 in IDLE and 1 in HEADER, PAYLOAD and GAP, so busy rises exactly one cycle after the accepted start.
REQ-022 data_valid SHALL be 1 in HEADER and PAYLOAD and 0 in IDLE and GAP.
REQ-023 A byte SHALL be transferred only when data_valid=1 and data_ready=1; otherwise data_out, data_sof and data_eof SHALL hold their values.
REQ-024 Header byte order by index:
  - 0-5: DST_MAC
  - 6-11: SRC_MAC
  - 12-13: ETHERTYPE
  - 14: txid
  - 15: aux
  - 16: segment_num[15:8]
  - 17: segment_num[7:0]
REQ-025 The transfer of index 17 SHALL move the block to PAYLOAD.
REQ-026 Payload byte k (0..PAYLOAD_LEN-1) SHALL equal (segment_num[7:0] + k) mod 256 and SHALL appear at index 18+k.
REQ-027 The byte index SHALL be 11 bits wide and SHALL advance by 1 on each transfer only.
REQ-028 data_sof SHALL be 1 only with index 0; data_eof SHALL be 1 only with index 17+PAYLOAD_LEN.
REQ-029 The transfer of the eof byte SHALL enter GAP with the gap counter at 0, or enter IDLE directly when IFG=0.
REQ-030 GAP SHALL last exactly IFG cycles regardless of data_ready, then return to IDLE.
REQ-031 A start_sending asserted in the same cycle that GAP exits SHALL be ignored; it is accepted only in IDLE.

Reset
REQ-032 rst=1 SHALL immediately force IDLE and clear busy, data_valid, data_sof, data_eof, data_out, the byte index, the gap counter and the latched fields to 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no eof; the first start after release SHALL begin a fresh frame at index 0.

Verification
REQ-034 Basic frame: defaults, data_ready=1, start with seg=16'h0102, txid=1, aux=0.
  - busy rises next cycle.
  - 82 bytes: FF x6, 00 0A 35 01 02 03, 88 B5, 01 00 01 02, then 02..41.
  - sof on the first byte, eof on byte 41; busy stays high 12 more cycles, then falls.
REQ-035 Back-pressure: data_ready toggles 1,0 each cycle; byte sequence identical to REQ-034, every byte held stable while data_ready=0, and the frame takes 163 cycles.
REQ-036 Ignored start: pulse start_sending at index 30 and again during GAP; no second frame, latched txid unchanged.
REQ-037 Wrap: seg=16'h00F0, PAYLOAD_LEN=64; payload is F0..FF, then 00..2F.
REQ-038 Abort: rst at index 20 gives all outputs 0 asynchronously; after release, start with txid=3 gives sof at index 0 and byte 14 = 03.
REQ-039 IFG=0: busy falls the cycle after the eof transfer, and an immediate start is accepted then.
